mc_control_unit: RTL and testbench
==================================

# mc_control_unit

Multicycle control sequencer for the single-issue MIPS core, replacing the purely combinational decoder with a state machine.
- Steps each instruction through fetch, decode, execute, memory and writeback, and holds memory requests until the cache acknowledges.
- Tracks an LL/SC link register with snoop invalidation, flags arithmetic overflow and detects memory timeouts.
- Sits between the instruction register/caches and the datapath muxes, register file and PC.

## Interface
Parameters
- WORD_W, 32, data/address width.
- WAIT_MAX, 255, cycles allowed for ihit/dhit before a memory error; 0 disables the timeout.
- LINK_EN, 1, enables LL/SC link tracking; when 0, SC always fails.

Ports
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, synchronous, active-high.
- instruction  in  32  instruction word from icache.
- ihit  in  1  icache ack.
- dhit  in  1  dcache ack.
- zero  in  1  ALU zero.
- alu_overflow  in  1  ALU signed overflow.
- daddr  in  WORD_W  ALU result used as data address.
- snoop_valid  in  1  coherence invalidate.
- snoop_addr  in  WORD_W  invalidated address.
- iREN, dREN, dWEN  out  1  memory requests.
- WEN  out  1  register file write.
- pc_en  out  1  PC update strobe.
- ir_en  out  1  instruction register load.
- halt  out  1  sticky halt.
- mem_err  out  1  sticky timeout flag.
- PCSrc, j, jr, jal, lui, sign_ext, shamt_en, ALUSrc, RegDest, MemReg, bne, atomic  out  1 each  datapath selects.
- ALUcode  out  aluop_t  ALU operation.
- sc_result  out  1  value written to rt by SC.
- overflow_flag  out  1  sticky overflow.
- state  out  3  debug encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALTED=5.

## Operation
- FETCH: iREN=1. On ihit: ir_en=1 for one cycle, go to DECODE.
- DECODE: latch decoded selects from IR; they stay constant until the next FETCH. HALT (opcode 0x3F) goes to HALTED. J goes to FETCH with pc_en=1. All others go to EXEC.
- EXEC, BEQ/BNE: PCSrc=zero^bne, pc_en=1, go to FETCH.
- EXEC, JR: pc_en=1, go to FETCH.
- EXEC, LW/SW/LL(0x30)/SC(0x38): go to MEM.
- EXEC, all others: go to WB.
- MEM, LW/LL: dREN=1 held until dhit.
  - LL at dhit: link_valid=1, link_addr=daddr.
- MEM, SW: dWEN=1 held until dhit.
- MEM, SC:
  - If link_valid and link_addr[W-1:2]==daddr[W-1:2]: dWEN=1 until dhit, sc_result=1.
  - Otherwise: no request, sc_result=0, go to WB the next cycle.
  - Link is cleared on SC exit either way.
- WB: pc_en=1, go to FETCH.
  - WEN=1, except: SW writes nothing, and ADD/ADDI/SUB with alu_overflow write nothing and set overflow_flag.
  - JAL writes in WB.
- HALTED: halt=1. Stays in HALTED until RST.
- Snoop: snoop_valid with word address equal to link_addr clears link_valid.
  - If this coincides with an LL dhit to the same word, clear wins and link_valid ends at 0.
- Timeout: a wait counter runs in FETCH/MEM while a request is pending and resets on each state entry.
  - When it reaches WAIT_MAX, set mem_err, drop the request and go to HALTED.
- Unknown opcode: treated as NOP (WB with WEN=0).

## Timing
- While RST=1: state=FETCH, all outputs 0, link_valid=0, counter=0, sticky flags cleared.
- First cycle with RST=0: iREN=1.
- Minimum latency with zero-wait memory: 4 cycles for ALU ops, 5 for loads/stores, 3 for branch/JR, 2 for J.
- Requests (iREN/dREN/dWEN) are Moore outputs of the state. They deassert in the cycle after the hit edge.
- ir_en, pc_en and WEN are single-cycle pulses.
- RST mid-MEM: the request drops at the next edge, with no pc_en or WEN for the aborted instruction.

## Test plan
- ADDU with ihit every cycle -> states 0,1,2,4; WEN=1 in cycle 4; pc_en=1 once.
- LW with dhit delayed 3 cycles -> dREN high for exactly 4 cycles, then WB with MemReg=1.
- LL to 0x100, then SC to 0x100 -> sc_result=1 with dWEN. Repeat with snoop_valid to 0x100 between them -> sc_result=0 and no dWEN.
- ADD with alu_overflow=1 -> WEN=0 in WB, overflow_flag=1 and held.
- WAIT_MAX=4, ihit never asserted -> mem_err=1 and halt=1 after 4 FETCH cycles; RST clears both.
- BNE with zero=0 -> PCSrc=1 with pc_en in EXEC; halt instruction -> halt stays high indefinitely.

Source files
------------

// File: rtl/mc_control_unit_if.sv
`default_nettype none
// ======================================================================
// mc_control_unit_if : ALU op encoding and control <-> datapath/cache bus
// Revision: 1.0
// ======================================================================
package mc_control_unit_pkg;
   typedef enum logic [3:0] {
      ALU_SLL  = 4'd0,
      ALU_SRL  = 4'd1,
      ALU_ADD  = 4'd2,
      ALU_SUB  = 4'd3,
      ALU_AND  = 4'd4,
      ALU_OR   = 4'd5,
      ALU_XOR  = 4'd6,
      ALU_NOR  = 4'd7,
      ALU_SLT  = 4'd8,
      ALU_SLTU = 4'd9
   } aluop_t;
endpackage

interface mc_control_unit_if #(
   parameter int WORD_W = 32
);
   import mc_control_unit_pkg::*;

   logic [31:0]       instruction;
   logic              ihit;
   logic              dhit;
   logic              zero;
   logic              alu_overflow;
   logic [WORD_W-1:0] daddr;
   logic              snoop_valid;
   logic [WORD_W-1:0] snoop_addr;

   logic              iREN;
   logic              dREN;
   logic              dWEN;
   logic              WEN;
   logic              pc_en;
   logic              ir_en;
   logic              halt;
   logic              mem_err;
   logic              PCSrc;
   logic              j;
   logic              jr;
   logic              jal;
   logic              lui;
   logic              sign_ext;
   logic              shamt_en;
   logic              ALUSrc;
   logic              RegDest;
   logic              MemReg;
   logic              bne;
   logic              atomic;
   aluop_t            ALUcode;
   logic              sc_result;
   logic              overflow_flag;
   logic [2:0]        state;

   modport master (
      input  instruction, ihit, dhit, zero, alu_overflow, daddr, snoop_valid, snoop_addr,
      output iREN, dREN, dWEN, WEN, pc_en, ir_en, halt, mem_err,
      output PCSrc, j, jr, jal, lui, sign_ext, shamt_en, ALUSrc, RegDest, MemReg, bne, atomic,
      output ALUcode, sc_result, overflow_flag, state
   );

   modport slave (
      output instruction, ihit, dhit, zero, alu_overflow, daddr, snoop_valid, snoop_addr,
      input  iREN, dREN, dWEN, WEN, pc_en, ir_en, halt, mem_err,
      input  PCSrc, j, jr, jal, lui, sign_ext, shamt_en, ALUSrc, RegDest, MemReg, bne, atomic,
      input  ALUcode, sc_result, overflow_flag, state
   );
endinterface

`default_nettype wire

// File: rtl/mc_control_unit.sv
`default_nettype none
// ======================================================================
// mc_control_unit : multicycle MIPS control sequencer with LL/SC link
// Revision: 1.0
// ======================================================================
module mc_control_unit
   import mc_control_unit_pkg::*;
#(
   parameter int WORD_W   = 32,
   parameter int WAIT_MAX = 255,
   parameter bit LINK_EN  = 1'b1
) (
   input  logic              CLK,
   input  logic              RST,
   mc_control_unit_if.master bus
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALTED = 3'd5
   } state_t;

   typedef enum logic [3:0] {
      K_NOP    = 4'd0,
      K_ALU    = 4'd1,
      K_BRANCH = 4'd2,
      K_JR     = 4'd3,
      K_J      = 4'd4,
      K_LOAD   = 4'd5,
      K_LL     = 4'd6,
      K_STORE  = 4'd7,
      K_SC     = 4'd8,
      K_HALT   = 4'd9
   } kind_t;

   localparam int               CNT_W       = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
   localparam logic [CNT_W-1:0] c_wait_last = CNT_W'((WAIT_MAX > 0) ? WAIT_MAX - 1 : 0);

   localparam logic [5:0] c_op_rtype = 6'h00;
   localparam logic [5:0] c_op_j     = 6'h02;
   localparam logic [5:0] c_op_jal   = 6'h03;
   localparam logic [5:0] c_op_beq   = 6'h04;
   localparam logic [5:0] c_op_bne   = 6'h05;
   localparam logic [5:0] c_op_addi  = 6'h08;
   localparam logic [5:0] c_op_addiu = 6'h09;
   localparam logic [5:0] c_op_slti  = 6'h0A;
   localparam logic [5:0] c_op_sltiu = 6'h0B;
   localparam logic [5:0] c_op_andi  = 6'h0C;
   localparam logic [5:0] c_op_ori   = 6'h0D;
   localparam logic [5:0] c_op_xori  = 6'h0E;
   localparam logic [5:0] c_op_lui   = 6'h0F;
   localparam logic [5:0] c_op_lw    = 6'h23;
   localparam logic [5:0] c_op_sw    = 6'h2B;
   localparam logic [5:0] c_op_ll    = 6'h30;
   localparam logic [5:0] c_op_sc    = 6'h38;
   localparam logic [5:0] c_op_halt  = 6'h3F;

   localparam logic [5:0] c_fn_sll   = 6'h00;
   localparam logic [5:0] c_fn_srl   = 6'h02;
   localparam logic [5:0] c_fn_jr    = 6'h08;
   localparam logic [5:0] c_fn_add   = 6'h20;
   localparam logic [5:0] c_fn_addu  = 6'h21;
   localparam logic [5:0] c_fn_sub   = 6'h22;
   localparam logic [5:0] c_fn_subu  = 6'h23;
   localparam logic [5:0] c_fn_and   = 6'h24;
   localparam logic [5:0] c_fn_or    = 6'h25;
   localparam logic [5:0] c_fn_xor   = 6'h26;
   localparam logic [5:0] c_fn_nor   = 6'h27;
   localparam logic [5:0] c_fn_slt   = 6'h2A;
   localparam logic [5:0] c_fn_sltu  = 6'h2B;

   state_t             r_state;
   kind_t              r_kind;
   aluop_t             r_alucode;
   logic               r_j, r_jr, r_jal, r_lui, r_sext, r_shamt, r_alusrc;
   logic               r_regdst, r_memreg, r_bne, r_atomic, r_ovf_chk;
   logic [CNT_W-1:0]   r_wait_cnt;
   logic               r_mem_err;
   logic               r_ovf_flag;
   logic               r_link_valid;
   logic [WORD_W-3:0]  r_link_word;
   logic               r_sc_result;

   kind_t              w_kind;
   aluop_t             w_alu;
   logic               w_j, w_jr, w_jal, w_lui, w_sext, w_shamt, w_alusrc;
   logic               w_regdst, w_memreg, w_bne, w_atomic, w_ovf_chk;
   logic [5:0]         w_op;
   logic [5:0]         w_fn;
   logic               w_run;
   logic               w_timeout;
   logic               w_snoop_link;
   logic               w_snoop_new;
   logic               w_sc_ok;
   logic               w_wen_ok;
   logic               w_ovf_hit;
   logic               w_unused_bits;

   assign w_op = bus.instruction[31:26];
   assign w_fn = bus.instruction[5:0];

   // Decode straight from the icache word; the result is latched on the fetch hit.
   always_comb begin
      w_kind    = K_NOP;
      w_alu     = ALU_ADD;
      w_j       = 1'b0;
      w_jr      = 1'b0;
      w_jal     = 1'b0;
      w_lui     = 1'b0;
      w_sext    = 1'b0;
      w_shamt   = 1'b0;
      w_alusrc  = 1'b0;
      w_regdst  = 1'b0;
      w_memreg  = 1'b0;
      w_bne     = 1'b0;
      w_atomic  = 1'b0;
      w_ovf_chk = 1'b0;
      case (w_op)
         c_op_rtype: begin
            w_regdst = 1'b1;
            w_kind   = K_ALU;
            case (w_fn)
               c_fn_sll:  begin w_alu = ALU_SLL; w_shamt = 1'b1; end
               c_fn_srl:  begin w_alu = ALU_SRL; w_shamt = 1'b1; end
               c_fn_jr:   begin w_kind = K_JR; w_jr = 1'b1; end
               c_fn_add:  begin w_alu = ALU_ADD; w_ovf_chk = 1'b1; end
               c_fn_addu: w_alu = ALU_ADD;
               c_fn_sub:  begin w_alu = ALU_SUB; w_ovf_chk = 1'b1; end
               c_fn_subu: w_alu = ALU_SUB;
               c_fn_and:  w_alu = ALU_AND;
               c_fn_or:   w_alu = ALU_OR;
               c_fn_xor:  w_alu = ALU_XOR;
               c_fn_nor:  w_alu = ALU_NOR;
               c_fn_slt:  w_alu = ALU_SLT;
               c_fn_sltu: w_alu = ALU_SLTU;
               default:   w_kind = K_NOP;
            endcase
         end
         c_op_j:     begin w_kind = K_J; w_j = 1'b1; end
         c_op_jal:   begin w_kind = K_ALU; w_j = 1'b1; w_jal = 1'b1; end
         c_op_beq:   begin w_kind = K_BRANCH; w_alu = ALU_SUB; w_sext = 1'b1; end
         c_op_bne:   begin w_kind = K_BRANCH; w_alu = ALU_SUB; w_sext = 1'b1; w_bne = 1'b1; end
         c_op_addi:  begin w_kind = K_ALU; w_alusrc = 1'b1; w_sext = 1'b1; w_ovf_chk = 1'b1; end
         c_op_addiu: begin w_kind = K_ALU; w_alusrc = 1'b1; w_sext = 1'b1; end
         c_op_slti:  begin w_kind = K_ALU; w_alu = ALU_SLT; w_alusrc = 1'b1; w_sext = 1'b1; end
         c_op_sltiu: begin w_kind = K_ALU; w_alu = ALU_SLTU; w_alusrc = 1'b1; w_sext = 1'b1; end
         c_op_andi:  begin w_kind = K_ALU; w_alu = ALU_AND; w_alusrc = 1'b1; end
         c_op_ori:   begin w_kind = K_ALU; w_alu = ALU_OR; w_alusrc = 1'b1; end
         c_op_xori:  begin w_kind = K_ALU; w_alu = ALU_XOR; w_alusrc = 1'b1; end
         c_op_lui:   begin w_kind = K_ALU; w_lui = 1'b1; w_alusrc = 1'b1; end
         c_op_lw:    begin w_kind = K_LOAD; w_alusrc = 1'b1; w_sext = 1'b1; w_memreg = 1'b1; end
         c_op_sw:    begin w_kind = K_STORE; w_alusrc = 1'b1; w_sext = 1'b1; end
         c_op_ll:    begin w_kind = K_LL; w_alusrc = 1'b1; w_sext = 1'b1; w_memreg = 1'b1; w_atomic = 1'b1; end
         c_op_sc:    begin w_kind = K_SC; w_alusrc = 1'b1; w_sext = 1'b1; w_atomic = 1'b1; end
         c_op_halt:  w_kind = K_HALT;
         default:    w_kind = K_NOP;
      endcase
   end

   assign w_timeout    = (WAIT_MAX != 0) && (r_wait_cnt == c_wait_last);
   assign w_snoop_link = bus.snoop_valid && r_link_valid &&
                         (bus.snoop_addr[WORD_W-1:2] == r_link_word);
   assign w_snoop_new  = bus.snoop_valid &&
                         (bus.snoop_addr[WORD_W-1:2] == bus.daddr[WORD_W-1:2]);
   // A snoop landing on the same edge as the SC check already kills the link.
   assign w_sc_ok      = LINK_EN && r_link_valid && !w_snoop_link &&
                         (r_link_word == bus.daddr[WORD_W-1:2]);
   assign w_wen_ok     = (r_kind == K_ALU) || (r_kind == K_LOAD) ||
                         (r_kind == K_LL) || (r_kind == K_SC);
   assign w_ovf_hit    = r_ovf_chk && bus.alu_overflow;
   assign w_unused_bits = ^{bus.instruction[25:6], bus.daddr[1:0], bus.snoop_addr[1:0]};

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state      <= S_FETCH;
         r_kind       <= K_NOP;
         r_alucode    <= ALU_SLL;
         r_j          <= 1'b0;
         r_jr         <= 1'b0;
         r_jal        <= 1'b0;
         r_lui        <= 1'b0;
         r_sext       <= 1'b0;
         r_shamt      <= 1'b0;
         r_alusrc     <= 1'b0;
         r_regdst     <= 1'b0;
         r_memreg     <= 1'b0;
         r_bne        <= 1'b0;
         r_atomic     <= 1'b0;
         r_ovf_chk    <= 1'b0;
         r_wait_cnt   <= '0;
         r_mem_err    <= 1'b0;
         r_ovf_flag   <= 1'b0;
         r_link_valid <= 1'b0;
         r_link_word  <= '0;
         r_sc_result  <= 1'b0;
      end else begin
         r_wait_cnt <= '0;
         if (w_snoop_link) begin
            r_link_valid <= 1'b0;
         end
         case (r_state)
            S_FETCH: begin
               if (bus.ihit) begin
                  r_kind      <= w_kind;
                  r_alucode   <= w_alu;
                  r_j         <= w_j;
                  r_jr        <= w_jr;
                  r_jal       <= w_jal;
                  r_lui       <= w_lui;
                  r_sext      <= w_sext;
                  r_shamt     <= w_shamt;
                  r_alusrc    <= w_alusrc;
                  r_regdst    <= w_regdst;
                  r_memreg    <= w_memreg;
                  r_bne       <= w_bne;
                  r_atomic    <= w_atomic;
                  r_ovf_chk   <= w_ovf_chk;
                  r_sc_result <= 1'b0;
                  r_state     <= S_DECODE;
               end else if (w_timeout) begin
                  r_mem_err <= 1'b1;
                  r_state   <= S_HALTED;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 1'b1;
               end
            end
            S_DECODE: begin
               if (r_kind == K_HALT) begin
                  r_state <= S_HALTED;
               end else if (r_kind == K_J) begin
                  r_state <= S_FETCH;
               end else begin
                  r_state <= S_EXEC;
               end
            end
            S_EXEC: begin
               case (r_kind)
                  K_BRANCH, K_JR:        r_state <= S_FETCH;
                  K_LOAD, K_LL, K_STORE: r_state <= S_MEM;
                  K_SC: begin
                     r_sc_result <= w_sc_ok;
                     r_state     <= S_MEM;
                  end
                  default:               r_state <= S_WB;
               endcase
            end
            S_MEM: begin
               if (r_kind == K_SC && !r_sc_result) begin
                  r_link_valid <= 1'b0;
                  r_state      <= S_WB;
               end else if (bus.dhit) begin
                  if (r_kind == K_LL && LINK_EN) begin
                     r_link_word  <= bus.daddr[WORD_W-1:2];
                     r_link_valid <= !w_snoop_new;
                  end
                  if (r_kind == K_SC) begin
                     r_link_valid <= 1'b0;
                  end
                  r_state <= S_WB;
               end else if (w_timeout) begin
                  r_mem_err <= 1'b1;
                  r_state   <= S_HALTED;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 1'b1;
               end
            end
            S_WB: begin
               if (w_ovf_hit) begin
                  r_ovf_flag <= 1'b1;
               end
               r_state <= S_FETCH;
            end
            S_HALTED: r_state <= S_HALTED;
            default:  r_state <= S_FETCH;
         endcase
      end
   end

   // Strobes are decoded from the state register and forced low while reset is held.
   assign w_run = !RST;

   assign bus.iREN    = w_run && (r_state == S_FETCH);
   assign bus.ir_en   = w_run && (r_state == S_FETCH) && bus.ihit;
   assign bus.dREN    = w_run && (r_state == S_MEM) && ((r_kind == K_LOAD) || (r_kind == K_LL));
   assign bus.dWEN    = w_run && (r_state == S_MEM) &&
                        ((r_kind == K_STORE) || ((r_kind == K_SC) && r_sc_result));
   assign bus.pc_en   = w_run && (((r_state == S_DECODE) && (r_kind == K_J)) ||
                                  ((r_state == S_EXEC) && ((r_kind == K_BRANCH) || (r_kind == K_JR))) ||
                                  (r_state == S_WB));
   assign bus.PCSrc   = w_run && (r_state == S_EXEC) && (r_kind == K_BRANCH) && (bus.zero ^ r_bne);
   assign bus.WEN     = w_run && (r_state == S_WB) && w_wen_ok && !w_ovf_hit;
   assign bus.halt    = w_run && (r_state == S_HALTED);
   assign bus.mem_err = r_mem_err;

   assign bus.j             = r_j;
   assign bus.jr            = r_jr;
   assign bus.jal           = r_jal;
   assign bus.lui           = r_lui;
   assign bus.sign_ext      = r_sext;
   assign bus.shamt_en      = r_shamt;
   assign bus.ALUSrc        = r_alusrc;
   assign bus.RegDest       = r_regdst;
   assign bus.MemReg        = r_memreg;
   assign bus.bne           = r_bne;
   assign bus.atomic        = r_atomic;
   assign bus.ALUcode       = r_alucode;
   assign bus.sc_result     = r_sc_result;
   assign bus.overflow_flag = r_ovf_flag;
   assign bus.state         = r_state;

endmodule

`default_nettype wire

// File: tb/tb_mc_control_unit.sv
`default_nettype none
// ======================================================================
// tb_mc_control_unit : directed self-checking bench for mc_control_unit
// Revision: 1.0
// ======================================================================
module tb_mc_control_unit;
   import mc_control_unit_pkg::*;

   localparam logic [31:0] c_i_addu = 32'h0022_1821;
   localparam logic [31:0] c_i_add  = 32'h0022_1820;
   localparam logic [31:0] c_i_lw   = 32'h8C22_0000;
   localparam logic [31:0] c_i_ll   = 32'hC022_0000;
   localparam logic [31:0] c_i_sc   = 32'hE022_0000;
   localparam logic [31:0] c_i_bne  = 32'h1422_0004;
   localparam logic [31:0] c_i_j    = 32'h0800_0010;
   localparam logic [31:0] c_i_unk  = 32'hF800_0000;
   localparam logic [31:0] c_i_halt = 32'hFC00_0000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail = 0;
   int   dren_cycles;

   mc_control_unit_if #(.WORD_W(32)) bus ();

   mc_control_unit #(
      .WORD_W   (32),
      .WAIT_MAX (4),
      .LINK_EN  (1'b1)
   ) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fetch(input logic [31:0] ins);
      bus.instruction = ins;
      bus.ihit = 1'b1;
      tick();
      bus.ihit = 1'b0;
   endtask

   task automatic run_ll(input logic snoop_at_hit);
      fetch(c_i_ll);
      bus.daddr = 32'h100;
      tick();
      tick();
      bus.dhit = 1'b1;
      if (snoop_at_hit) begin
         bus.snoop_valid = 1'b1;
         bus.snoop_addr  = 32'h100;
      end
      tick();
      bus.dhit = 1'b0;
      bus.snoop_valid = 1'b0;
      tick();
   endtask

   initial begin
      bus.instruction  = 32'h0;
      bus.ihit         = 1'b0;
      bus.dhit         = 1'b0;
      bus.zero         = 1'b0;
      bus.alu_overflow = 1'b0;
      bus.daddr        = 32'h0;
      bus.snoop_valid  = 1'b0;
      bus.snoop_addr   = 32'h0;
      tick();
      tick();
      check("rst_state", 32'(bus.state), 32'd0);
      check("rst_iren", 32'(bus.iREN), 32'd0);
      check("rst_pc_en", 32'(bus.pc_en), 32'd0);
      check("rst_wen", 32'(bus.WEN), 32'd0);
      check("rst_halt", 32'(bus.halt), 32'd0);
      check("rst_mem_err", 32'(bus.mem_err), 32'd0);

      rst = 1'b0;
      #1;
      check("first_iren", 32'(bus.iREN), 32'd1);

      // ADDU with zero-wait fetch: FETCH, DECODE, EXEC, WB
      bus.instruction = c_i_addu;
      bus.ihit = 1'b1;
      #1;
      check("addu_ir_en", 32'(bus.ir_en), 32'd1);
      tick();
      bus.ihit = 1'b0;
      check("addu_dec_state", 32'(bus.state), 32'd1);
      check("addu_dec_iren", 32'(bus.iREN), 32'd0);
      check("addu_dec_ir_en", 32'(bus.ir_en), 32'd0);
      check("addu_regdest", 32'(bus.RegDest), 32'd1);
      check("addu_alucode", 32'(bus.ALUcode), 32'd2);
      tick();
      check("addu_exec_state", 32'(bus.state), 32'd2);
      check("addu_exec_pc_en", 32'(bus.pc_en), 32'd0);
      tick();
      check("addu_wb_state", 32'(bus.state), 32'd4);
      check("addu_wb_wen", 32'(bus.WEN), 32'd1);
      check("addu_wb_pc_en", 32'(bus.pc_en), 32'd1);
      tick();
      check("addu_back_state", 32'(bus.state), 32'd0);
      check("addu_back_pc_en", 32'(bus.pc_en), 32'd0);
      check("addu_back_wen", 32'(bus.WEN), 32'd0);

      // LW, dhit three cycles late: dREN on for four MEM cycles
      fetch(c_i_lw);
      check("lw_memreg", 32'(bus.MemReg), 32'd1);
      check("lw_alusrc", 32'(bus.ALUSrc), 32'd1);
      bus.daddr = 32'h40;
      tick();
      tick();
      dren_cycles = 0;
      for (int i = 0; i < 4; i++) begin
         if (bus.dREN) dren_cycles++;
         bus.dhit = (i == 3);
         tick();
      end
      bus.dhit = 1'b0;
      check("lw_dren_cycles", 32'(dren_cycles), 32'd4);
      check("lw_wb_state", 32'(bus.state), 32'd4);
      check("lw_wb_dren", 32'(bus.dREN), 32'd0);
      check("lw_wb_wen", 32'(bus.WEN), 32'd1);
      check("lw_wb_memreg", 32'(bus.MemReg), 32'd1);
      tick();

      // LL then SC to the same word succeeds
      run_ll(1'b0);
      fetch(c_i_sc);
      tick();
      tick();
      check("sc1_dwen", 32'(bus.dWEN), 32'd1);
      check("sc1_result", 32'(bus.sc_result), 32'd1);
      check("sc1_atomic", 32'(bus.atomic), 32'd1);
      bus.dhit = 1'b1;
      tick();
      bus.dhit = 1'b0;
      check("sc1_wb_dwen", 32'(bus.dWEN), 32'd0);
      check("sc1_wb_wen", 32'(bus.WEN), 32'd1);
      tick();

      // Snoop to the linked word between LL and SC makes the SC fail
      run_ll(1'b0);
      bus.snoop_valid = 1'b1;
      bus.snoop_addr  = 32'h100;
      fetch(c_i_sc);
      bus.snoop_valid = 1'b0;
      tick();
      tick();
      check("sc2_dwen", 32'(bus.dWEN), 32'd0);
      check("sc2_result", 32'(bus.sc_result), 32'd0);
      tick();
      check("sc2_wb_state", 32'(bus.state), 32'd4);
      check("sc2_wb_wen", 32'(bus.WEN), 32'd1);
      tick();

      // Snoop coinciding with the LL dhit leaves no link
      run_ll(1'b1);
      fetch(c_i_sc);
      tick();
      tick();
      check("sc3_dwen", 32'(bus.dWEN), 32'd0);
      check("sc3_result", 32'(bus.sc_result), 32'd0);
      tick();
      tick();

      // ADD with overflow: no write, sticky flag
      fetch(c_i_add);
      tick();
      tick();
      bus.alu_overflow = 1'b1;
      #1;
      check("add_ovf_wen", 32'(bus.WEN), 32'd0);
      check("add_ovf_pc_en", 32'(bus.pc_en), 32'd1);
      tick();
      bus.alu_overflow = 1'b0;
      check("add_ovf_flag", 32'(bus.overflow_flag), 32'd1);

      // BNE: PCSrc = zero ^ bne in EXEC
      fetch(c_i_bne);
      check("bne_sel", 32'(bus.bne), 32'd1);
      bus.zero = 1'b0;
      tick();
      check("bne_exec_state", 32'(bus.state), 32'd2);
      check("bne_pcsrc", 32'(bus.PCSrc), 32'd1);
      check("bne_pc_en", 32'(bus.pc_en), 32'd1);
      bus.zero = 1'b1;
      #1;
      check("bne_pcsrc_zero", 32'(bus.PCSrc), 32'd0);
      tick();
      bus.zero = 1'b0;
      check("bne_back_state", 32'(bus.state), 32'd0);
      check("ovf_flag_held", 32'(bus.overflow_flag), 32'd1);

      // J finishes in DECODE
      fetch(c_i_j);
      check("j_pc_en", 32'(bus.pc_en), 32'd1);
      check("j_sel", 32'(bus.j), 32'd1);
      tick();
      check("j_back_state", 32'(bus.state), 32'd0);

      // Unknown opcode behaves as NOP
      fetch(c_i_unk);
      tick();
      tick();
      check("unk_wb_state", 32'(bus.state), 32'd4);
      check("unk_wb_wen", 32'(bus.WEN), 32'd0);
      check("unk_wb_pc_en", 32'(bus.pc_en), 32'd1);
      tick();

      // HALT is sticky
      fetch(c_i_halt);
      tick();
      check("halt_state", 32'(bus.state), 32'd5);
      check("halt_out", 32'(bus.halt), 32'd1);
      bus.ihit = 1'b1;
      repeat (5) tick();
      bus.ihit = 1'b0;
      check("halt_held", 32'(bus.halt), 32'd1);
      check("halt_iren", 32'(bus.iREN), 32'd0);

      rst = 1'b1;
      tick();
      check("rst2_halt", 32'(bus.halt), 32'd0);
      check("rst2_ovf_flag", 32'(bus.overflow_flag), 32'd0);
      check("rst2_state", 32'(bus.state), 32'd0);

      // Fetch timeout with WAIT_MAX=4
      rst = 1'b0;
      tick();
      tick();
      tick();
      check("to_fetch4_iren", 32'(bus.iREN), 32'd1);
      check("to_fetch4_state", 32'(bus.state), 32'd0);
      check("to_fetch4_mem_err", 32'(bus.mem_err), 32'd0);
      tick();
      check("to_halt", 32'(bus.halt), 32'd1);
      check("to_mem_err", 32'(bus.mem_err), 32'd1);
      check("to_iren_off", 32'(bus.iREN), 32'd0);
      rst = 1'b1;
      tick();
      check("to_clr_halt", 32'(bus.halt), 32'd0);
      check("to_clr_mem_err", 32'(bus.mem_err), 32'd0);

      // Reset in the middle of a load
      rst = 1'b0;
      fetch(c_i_lw);
      tick();
      tick();
      check("mid_dren", 32'(bus.dREN), 32'd1);
      rst = 1'b1;
      tick();
      check("mid_dren_off", 32'(bus.dREN), 32'd0);
      check("mid_pc_en", 32'(bus.pc_en), 32'd0);
      check("mid_wen", 32'(bus.WEN), 32'd0);
      check("mid_state", 32'(bus.state), 32'd0);
      rst = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
